// File: rtl/ifu_pkg.sv
// Shared constants and FSM state type for the IFU fetch-path memory responder.
package ifu_pkg;
    localparam int   ADDR_WIDTH   = 32;
    localparam int   OFFSET_WIDTH = 4;
    localparam int   TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int   LINE_WIDTH   = 128;
    localparam int   MEM_LATENCY  = 4;
    localparam logic VALID        = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } t_mem_rsp_state;
endpackage

// File: rtl/ifu_mem_rsp_queue.sv
// In-order pending-request FIFO with parallel tag match for coalescing and an
// empty-queue bypass so a fresh request can be taken into service on its own edge.
module ifu_mem_rsp_queue
    import ifu_pkg::*;
#(
    parameter int TAG_W = TAG_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [TAG_W-1:0] head_o,
    output logic             head_vld_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             match_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 2;

    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W-1:0] count;
    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] offs;
    logic             bypass, do_push, do_pop;

    assign count      = wr_q - rd_q;
    assign empty_o    = (count == '0);
    assign full_o     = (count == PTR_W'(DEPTH));
    assign head_vld_o = !empty_o || push_i;
    assign head_o     = empty_o ? tag_i : mem_q[rd_q[IDX_W-1:0]];

    // A push into an empty queue that is popped on the same edge never touches storage.
    assign bypass  = empty_o && push_i && pop_i;
    assign do_push = push_i && !bypass && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        match_o = 1'b0;
        offs    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = IDX_W'(i) - rd_q[IDX_W-1:0];
            if ((mem_q[i] == tag_i) && ({2'b00, offs} < count)) begin
                match_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + PTR_W'(do_push);
            rd_q <= rd_q + PTR_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[IDX_W-1:0]] <= tag_i;
        end
    end
endmodule

// File: rtl/ifu_mem_rsp.sv
// IFU fetch-protocol memory responder: queues line-tag requests and returns the
// preloaded instruction line with its tag a fixed number of cycles later.
module ifu_mem_rsp
    import ifu_pkg::*;
#(
    parameter int ADDR_WIDTH   = ifu_pkg::ADDR_WIDTH,
    parameter int OFFSET_WIDTH = ifu_pkg::OFFSET_WIDTH,
    parameter int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH,
    parameter int LINE_WIDTH   = ifu_pkg::LINE_WIDTH,
    parameter int MEM_LINES    = 256,
    parameter int QUEUE_DEPTH  = 4,
    parameter int MEM_LATENCY  = ifu_pkg::MEM_LATENCY
) (
    input  logic                         Clock,
    input  logic                         Rst,
    input  logic [TAG_WIDTH-1:0]         mem_reqTagIn,
    input  logic                         mem_reqTagValidIn,
    output logic [TAG_WIDTH-1:0]         mem_rspTagOut,
    output logic [LINE_WIDTH-1:0]        mem_rspInsLineOut,
    output logic                         mem_rspInsLineValidOut,
    input  logic                         ld_wrEnIn,
    input  logic [$clog2(MEM_LINES)-1:0] ld_wrIdxIn,
    input  logic [LINE_WIDTH-1:0]        ld_wrLineIn,
    output logic                         err_overflowOut,
    output logic                         busyOut
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(MEM_LATENCY);

    t_mem_rsp_state        state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [TAG_WIDTH-1:0]  svc_tag_q, rsp_tag_q;
    logic [LINE_WIDTH-1:0] rsp_line_q;
    logic                  rsp_vld_q;
    logic                  err_q, err_d;
    logic [LINE_WIDTH-1:0] mem_q [MEM_LINES];

    logic [TAG_WIDTH-1:0]  q_head;
    logic                  q_head_vld, q_full, q_empty, q_match;
    logic                  svc_active, can_pop, coalesce, push, pop, drop;

    // The IFU holds valid across a miss, so a tag already pending or in service is absorbed.
    assign svc_active = (state_q != IDLE);
    assign can_pop    = (state_q == IDLE) || (state_q == RESP);
    assign coalesce   = q_match || (svc_active && (mem_reqTagIn == svc_tag_q));
    assign push       = mem_reqTagValidIn && !coalesce;
    assign pop        = can_pop && q_head_vld;
    assign drop       = push && q_full && !pop;
    assign err_d      = err_q || drop;

    ifu_mem_rsp_queue #(
        .TAG_W (TAG_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i      (Clock),
        .rst_i      (Rst),
        .tag_i      (mem_reqTagIn),
        .push_i     (push),
        .pop_i      (pop),
        .head_o     (q_head),
        .head_vld_o (q_head_vld),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .match_o    (q_match)
    );

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            svc_tag_q  <= '0;
            rsp_tag_q  <= '0;
            rsp_line_q <= '0;
            rsp_vld_q  <= 1'b0;
        end else begin
            rsp_vld_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (pop) begin
                        svc_tag_q <= q_head;
                        cnt_q     <= CNT_W'(MEM_LATENCY - 2);
                        state_q   <= WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_tag_q  <= svc_tag_q;
                        rsp_line_q <= mem_q[svc_tag_q[IDX_W-1:0]];
                        rsp_vld_q  <= VALID;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Line array is never reset; a same-edge response read sees the pre-write contents.
    always_ff @(posedge Clock) begin
        if (ld_wrEnIn) begin
            mem_q[ld_wrIdxIn] <= ld_wrLineIn;
        end
    end

    assign mem_rspTagOut          = rsp_tag_q;
    assign mem_rspInsLineOut      = rsp_line_q;
    assign mem_rspInsLineValidOut = rsp_vld_q;
    assign err_overflowOut        = err_q;
    assign busyOut                = !q_empty || (state_q != IDLE);
endmodule

// File: tb/tb_ifu_mem_rsp.sv
// Self-checking bench for ifu_mem_rsp: directed vector table, hand sequences for
// the multi-cycle corners, and random traffic against a timestamp-based model.
module tb_ifu_mem_rsp;
    localparam int TW = 28;
    localparam int LW = 128;
    localparam int L  = 4;
    localparam int D  = 4;
    localparam logic [LW-1:0] K5 = 128'h0123456789ABCDEF0123456789ABCDEF;

    typedef logic [TW-1:0] tag_t;
    typedef logic [LW-1:0] line_t;

    logic       clk, rst;
    tag_t       req_tag;
    logic       req_vld;
    tag_t       rsp_tag;
    line_t      rsp_line;
    logic       rsp_vld;
    logic       ld_en;
    logic [7:0] ld_idx;
    line_t      ld_line;
    logic       err, busy;

    ifu_mem_rsp dut (
        .Clock                  (clk),
        .Rst                    (rst),
        .mem_reqTagIn           (req_tag),
        .mem_reqTagValidIn      (req_vld),
        .mem_rspTagOut          (rsp_tag),
        .mem_rspInsLineOut      (rsp_line),
        .mem_rspInsLineValidOut (rsp_vld),
        .ld_wrEnIn              (ld_en),
        .ld_wrIdxIn             (ld_idx),
        .ld_wrLineIn            (ld_line),
        .err_overflowOut        (err),
        .busyOut                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;

    // Reference model: pending FIFO of tags plus the start edge of the request in service.
    tag_t  mq[$];
    line_t mmem [256];
    bit    m_act;
    int    m_start;
    tag_t  m_svc;
    int    k = 0;
    logic  m_vld, m_err;
    tag_t  m_tag;
    line_t m_line;

    typedef struct {
        logic v;
        tag_t t;
        logic ev;
        tag_t et;
    } vec_t;
    vec_t tbl[23];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic line_t pat(input int i);
        if (i == 5) return K5;
        return {32'hC0DE0000 | 32'(i), ~32'(i), 32'(i) * 32'h01010101, 32'h12345678 + 32'(i)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_act  = 0;
        m_vld  = 0;
        m_err  = 0;
        m_tag  = '0;
        m_line = '0;
    endtask

    task automatic model_edge(input logic v, input tag_t t, input logic le,
                              input logic [7:0] li, input line_t ll);
        bit coal, can_pop;
        m_vld = 0;
        if (m_act && k == m_start + L - 1) begin
            m_vld  = 1;
            m_tag  = m_svc;
            m_line = mmem[m_svc[7:0]];
        end
        coal = 0;
        if (v) begin
            foreach (mq[i]) if (mq[i] == t) coal = 1;
            if (m_act && m_svc == t) coal = 1;
        end
        can_pop = !m_act || (k == m_start + L);
        if (v && !coal) begin
            if (mq.size() == D && !can_pop) m_err = 1;
            else mq.push_back(t);
        end
        if (can_pop) begin
            if (mq.size() > 0) begin
                m_svc   = mq.pop_front();
                m_start = k;
                m_act   = 1;
            end else begin
                m_act = 0;
            end
        end
        if (le) mmem[li] = ll;
        k++;
    endtask

    task automatic step(input logic v, input tag_t t, input logic le,
                        input logic [7:0] li, input line_t ll);
        req_vld = v;
        req_tag = t;
        ld_en   = le;
        ld_idx  = li;
        ld_line = ll;
        model_edge(v, t, le, li, ll);
        @(posedge clk);
        #1;
        if (rsp_vld === 1'b1) pulses++;
        chk("rsp_valid", rsp_vld, m_vld);
        chk("rsp_tag", rsp_tag, m_tag);
        chk("rsp_line", rsp_line, m_line);
        chk("overflow", err, m_err);
        chk("busy", busy, (m_act || mq.size() > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'h0, '0);
    endtask

    initial begin
        int p0;
        line_t new7;
        rst = 1'b1;
        req_vld = 0; req_tag = '0; ld_en = 0; ld_idx = '0; ld_line = '0;
        model_reset();
        #12;
        chk("reset_valid", rsp_vld, 1'b0);
        chk("reset_tag", rsp_tag, '0);
        chk("reset_line", rsp_line, '0);
        chk("reset_overflow", err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        #5 rst = 1'b0;

        for (int i = 0; i < 256; i++) step(1'b0, '0, 1'b1, 8'(i), pat(i));

        // Single request to index 5, then four back-to-back requests.
        for (int i = 0; i < 23; i++) tbl[i] = '{1'b0, '0, 1'b0, '0};
        tbl[0]  = '{1'b1, 28'h0000005, 1'b0, '0};
        tbl[3]  = '{1'b0, '0, 1'b1, 28'h0000005};
        tbl[6]  = '{1'b1, 28'h1, 1'b0, '0};
        tbl[7]  = '{1'b1, 28'h2, 1'b0, '0};
        tbl[8]  = '{1'b1, 28'h3, 1'b0, '0};
        tbl[9]  = '{1'b1, 28'h4, 1'b1, 28'h1};
        tbl[13] = '{1'b0, '0, 1'b1, 28'h2};
        tbl[17] = '{1'b0, '0, 1'b1, 28'h3};
        tbl[21] = '{1'b0, '0, 1'b1, 28'h4};
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].v, tbl[i].t, 1'b0, 8'h0, '0);
            chk($sformatf("tbl%0d_valid", i), rsp_vld, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_tag", i), rsp_tag, tbl[i].et);
                chk($sformatf("tbl%0d_line", i), rsp_line, pat(int'(tbl[i].et[7:0])));
            end
        end

        // IFU holds valid through the response cycle, then drops it.
        p0 = pulses;
        for (int i = 0; i < 5; i++) step(1'b1, 28'h5, 1'b0, 8'h0, '0);
        idle(6);
        chk("held_rsp_count", pulses - p0, 1);
        chk("held_no_ovf", err, 1'b0);

        // Preload collides with the response read of aliased tag 0x107.
        new7 = 128'hFEEDFACE_00000007_DEADBEEF_07070707;
        step(1'b1, 28'h107, 1'b0, 8'h0, '0);
        idle(2);
        step(1'b0, '0, 1'b1, 8'h07, new7);
        chk("rbw_valid", rsp_vld, 1'b1);
        chk("rbw_tag", rsp_tag, 28'h107);
        chk("rbw_old_line", rsp_line, pat(7));
        idle(2);
        step(1'b1, 28'h107, 1'b0, 8'h0, '0);
        idle(3);
        chk("rbw_new_valid", rsp_vld, 1'b1);
        chk("rbw_new_line", rsp_line, new7);
        idle(3);

        // The RESP-exit pop frees a slot mid-burst, so the seventh distinct request overflows.
        p0 = pulses;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 28'h20 + 28'(i), 1'b0, 8'h0, '0);
            if (i == 5) chk("ovf_not_yet", err, 1'b0);
        end
        chk("ovf_set", err, 1'b1);
        idle(30);
        chk("ovf_served", pulses - p0, 6);
        chk("ovf_sticky", err, 1'b1);

        // Asynchronous reset mid-WAIT with two entries queued.
        step(1'b1, 28'h30, 1'b0, 8'h0, '0);
        step(1'b1, 28'h31, 1'b0, 8'h0, '0);
        step(1'b1, 28'h32, 1'b0, 8'h0, '0);
        req_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", rsp_vld, 1'b0);
        chk("arst_tag", rsp_tag, '0);
        chk("arst_line", rsp_line, '0);
        chk("arst_overflow", err, 1'b0);
        chk("arst_busy", busy, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        p0 = pulses;
        idle(10);
        chk("arst_no_rsp", pulses - p0, 0);
        step(1'b1, 28'h5, 1'b0, 8'h0, '0);
        idle(3);
        chk("arst_mem_valid", rsp_vld, 1'b1);
        chk("arst_mem_kept", rsp_line, K5);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) != 0,
                 (tag_t'($urandom % 4) << 8) | tag_t'($urandom % 12),
                 ($urandom % 8) == 0,
                 8'($urandom % 16),
                 {$urandom, $urandom, $urandom, $urandom});
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
